// File: rtl/register_file.sv
// Multi-port register file with per-entry valid bits, write-first bypass,
// a synchronous invalidate-all, and a running count of valid entries.
module register_file #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] Data,
    input  logic             clear,
    input  logic [AW-1:0]    rd_addr_a,
    input  logic [AW-1:0]    rd_addr_b,
    output logic [WIDTH-1:0] Q_a,
    output logic [WIDTH-1:0] Q_b,
    output logic             valid_a,
    output logic             valid_b,
    output logic [CW-1:0]    count
);

    localparam int          DEPTH_P = DEPTH;
    localparam logic [AW:0] DEPTH_L = DEPTH_P[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] qa_q, qa_d, qb_q, qb_d;
    logic             va_q, va_d, vb_q, vb_d;
    logic             wr_ok;

    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

    always_comb begin
        wr_ok = enable && !clear && in_range(wr_addr);
        mem_d = mem_q;
        vld_d = vld_q;
        cnt_d = cnt_q;
        qa_d  = '0;
        va_d  = 1'b0;
        qb_d  = '0;
        vb_d  = 1'b0;

        if (clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i] = '0;
            end
            vld_d = '0;
            cnt_d = '0;
        end else if (wr_ok) begin
            mem_d[wr_addr] = Data;
            vld_d[wr_addr] = 1'b1;
            if (!vld_q[wr_addr]) begin
                cnt_d = cnt_q + CW'(1);
            end
        end

        // Reads look at the post-edge contents, which gives write-first
        // bypass and zero/invalid results on a clear edge for free.
        if (in_range(rd_addr_a) && vld_d[rd_addr_a]) begin
            qa_d = mem_d[rd_addr_a];
            va_d = 1'b1;
        end
        if (in_range(rd_addr_b) && vld_d[rd_addr_b]) begin
            qb_d = mem_d[rd_addr_b];
            vb_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q <= '0;
            cnt_q <= '0;
            qa_q  <= '0;
            va_q  <= 1'b0;
            qb_q  <= '0;
            vb_q  <= 1'b0;
        end else begin
            mem_q <= mem_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
            qa_q  <= qa_d;
            va_q  <= va_d;
            qb_q  <= qb_d;
            vb_q  <= vb_d;
        end
    end

    assign Q_a     = qa_q;
    assign valid_a = va_q;
    assign Q_b     = qb_q;
    assign valid_b = vb_q;
    assign count   = cnt_q;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 The block SHALL have parameter WIDTH, default 5, meaning data width per entry in bits (legal 1..32).
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning number of entries (legal 2..32, need not be a power of 2).
REQ-003 The block SHALL have derived localparam AW = clog2(DEPTH), meaning address width, and CW = clog2(DEPTH+1), meaning count width.
REQ-004 The block SHALL have port clk, input, 1, meaning single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1, meaning reset; synchronous, active-high.
REQ-006 The block SHALL have port enable, input, 1, meaning write strobe.
REQ-007 The block SHALL have port wr_addr, input, AW, meaning write entry index.
REQ-008 The block SHALL have port Data, input, WIDTH, meaning write data.
REQ-009 The block SHALL have port clear, input, 1, meaning synchronous invalidate-all.
REQ-010 The block SHALL have ports rd_addr_a and rd_addr_b, input, AW each, meaning read indices for ports A and B.
REQ-011 The block SHALL have ports Q_a and Q_b, output, WIDTH each, meaning registered read data.
REQ-012 The block SHALL have ports valid_a and valid_b, output, 1 each, meaning the entry read was valid.
REQ-013 The block SHALL have port count, output, CW, meaning number of currently valid entries.

Function
REQ-014 Write: on a rising edge with enable=1, clear=0, rst=0 and wr_addr<DEPTH, entry[wr_addr] SHALL take Data and its valid bit SHALL be set.
REQ-015 Entries SHALL hold their value on every edge without a qualifying write; there SHALL be no level-sensitive or latch behaviour.
REQ-016 Write with wr_addr>=DEPTH SHALL be ignored: no entry, valid bit or count change.
REQ-017 Read: Q_x/valid_x SHALL be registered, updating one clock after rd_addr_x is sampled (latency 1).
REQ-018 Bypass: if a qualifying write and a read target the same index on the same edge, the read output SHALL return the new Data with valid=1 (write-first).
REQ-019 Read with rd_addr_x>=DEPTH SHALL return Q_x=0, valid_x=0.
REQ-020 Read of an invalid entry SHALL return Q_x=0, valid_x=0, regardless of stored bits.
REQ-021 Ports A and B SHALL be independent; equal addresses SHALL return identical results.
REQ-022 count SHALL increment by 1 on a qualifying write to a currently invalid entry, and SHALL be unchanged on a write to an already valid entry (overwrite).
REQ-023 count SHALL never exceed DEPTH; when count=DEPTH, further writes SHALL only overwrite.
REQ-024 Clear: on an edge with clear=1, all valid bits SHALL clear, all entries SHALL zero, and count SHALL become 0.
REQ-025 clear and enable on the same edge: clear SHALL win; the write SHALL be discarded.
REQ-026 Read outputs on a clear edge SHALL register 0/invalid; bypass SHALL NOT apply when clear=1.
REQ-027 count SHALL be registered and SHALL reflect the edge's write or clear in the following cycle.

Reset
REQ-028 On an edge with rst=1, all entries, valid bits, Q_a, Q_b, valid_a, valid_b and count SHALL become 0.
REQ-029 rst SHALL take priority over clear and enable; a write coincident with rst SHALL be lost.
REQ-030 Deasserting rst mid-sequence SHALL leave the block in the empty state; the first write after SHALL increment count from 0.
REQ-031 Outputs before the first reset edge are undefined; the bench SHALL apply rst for at least 1 cycle.

Verification
REQ-032 Default params, reset then write 5'h1A to 3, then read A=3 -> Q_a=5'h1A, valid_a=1 one cycle later; count=1.
REQ-033 Write 5'h07 to 2 with rd_addr_b=2 on the same edge -> next cycle Q_b=5'h07, valid_b=1 (bypass); read of untouched 4 -> Q=0, valid=0.
REQ-034 Fill all 8 entries, then overwrite entry 0 with 5'h1F -> count stays 8, read 0 returns 5'h1F.
REQ-035 enable=1 and clear=1 on the same edge, wr_addr=5 -> count=0, read 5 returns Q=0, valid=0.
REQ-036 DEPTH=6: write to addr 7 -> count unchanged, read 7 -> Q=0, valid=0; write addr 5 -> count+1.
REQ-037 rst asserted after 4 writes, coincident with a write to 6 -> all outputs 0, count=0, read 6 invalid.
